// File: rtl/column_write_sequencer.sv
// column_write_sequencer
// Feeds ray-cast column records into the VGA column decoder. Each record is
// buffered in a small FIFO and sent as a 4-beat, 16-bit write group:
//   B0 {6'b0, dir, tex_type, tex_col}, B1 height, B2 top, B3 sf.
// The column index tracks the decoder's write-side column counter, and the
// block pulses frame_done on the frame wrap and sof_error on misalignment.
// Optional build macro: COLSEQ_IDLE_GAP_EN inserts one idle cycle after
// every beat (8-cycle groups); without it the beats are back-to-back.
module column_write_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_COLS   = 640
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic signed [15:0] in_top,
    input  logic [15:0]        in_height,
    input  logic [15:0]        in_sf,
    input  logic               in_dir,
    input  logic [2:0]         in_tex_type,
    input  logic [5:0]         in_tex_col,
    output logic               out_write,
    output logic               out_chipselect,
    output logic [15:0]        out_writedata,
    output logic [9:0]         col_index,
    output logic               frame_done,
    output logic               sof_error
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [9:0]    LAST_COL   = 10'(NUM_COLS - 1);

    typedef struct packed {
        logic        sof;
        logic [15:0] top;
        logic [15:0] height;
        logic [15:0] sf;
        logic        dir;
        logic [2:0]  tex_type;
        logic [5:0]  tex_col;
    } col_rec_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4
    } state_t;

    // Record buffer
    col_rec_t      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    col_rec_t      in_rec;
    col_rec_t      head_rec;

    // Fields of the column being emitted; B0 is taken straight from the head
    logic signed [15:0] hold_top;
    logic [15:0]        hold_height;
    logic [15:0]        hold_sf;

    // Sequencer
    state_t      state;
    state_t      state_next;
    logic        in_beat;
    logic        advance;
    logic        beat_next;
    logic [15:0] wdata_next;
`ifdef COLSEQ_IDLE_GAP_EN
    logic        gap;
    logic        gap_next;
`endif

    // Column counting
    logic       col_inc;
    logic       col_wrap;
    logic [9:0] col_next;

    assign in_rec     = {in_sof, in_top, in_height, in_sf, in_dir, in_tex_type, in_tex_col};
    assign head_rec   = fifo_mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign in_ready   = (count != FULL_COUNT);
    assign push       = in_valid && in_ready;

    assign out_chipselect = out_write;

    // FIFO storage: data only, written on accepted records
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_rec;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Capture the popped record's remaining beat fields for B1..B3
    always_ff @(posedge clk) begin
        if (pop) begin
            hold_top    <= head_rec.top;
            hold_height <= head_rec.height;
            hold_sf     <= head_rec.sf;
        end
    end

    // Next-state logic: IDLE waits for a record, B-states step once per beat
    always_comb begin
        state_next = state;
        pop        = 1'b0;
`ifdef COLSEQ_IDLE_GAP_EN
        in_beat    = (state != IDLE) && !gap;
        advance    = (state != IDLE) && gap;
        gap_next   = in_beat;
`else
        in_beat    = (state != IDLE);
        advance    = in_beat;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = B0;
                end
            end
            B0: begin
                if (advance) state_next = B1;
            end
            B1: begin
                if (advance) state_next = B2;
            end
            B2: begin
                if (advance) state_next = B3;
            end
            B3: begin
                if (advance) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = B0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat strobe and payload for the coming cycle; payload holds between beats
    always_comb begin
`ifdef COLSEQ_IDLE_GAP_EN
        beat_next = (state_next != IDLE) && !gap_next;
`else
        beat_next = (state_next != IDLE);
`endif
        wdata_next = out_writedata;
        if (beat_next) begin
            case (state_next)
                B0:      wdata_next = {6'b0, head_rec.dir, head_rec.tex_type, head_rec.tex_col};
                B1:      wdata_next = hold_height;
                B2:      wdata_next = hold_top;
                B3:      wdata_next = hold_sf;
                default: wdata_next = out_writedata;
            endcase
        end
    end

    // Column index advances when the B3 beat is issued and wraps at the last column
    always_comb begin
        col_inc  = (state == B3) && in_beat;
        col_wrap = col_inc && (col_index == LAST_COL);
        col_next = col_index;
        if (col_wrap) begin
            col_next = '0;
        end else if (col_inc) begin
            col_next = col_index + 10'd1;
        end
    end

    // Sequencer state and registered outputs; sof is checked against the column the popped record will occupy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            out_write     <= 1'b0;
            out_writedata <= '0;
            col_index     <= '0;
            frame_done    <= 1'b0;
            sof_error     <= 1'b0;
        end else begin
            state         <= state_next;
            out_write     <= beat_next;
            out_writedata <= wdata_next;
            col_index     <= col_next;
            frame_done    <= col_wrap;
            sof_error     <= pop && (head_rec.sof != (col_next == 10'd0));
        end
    end

`ifdef COLSEQ_IDLE_GAP_EN
    // Gap phase toggles after every beat so each write is followed by an idle cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap <= 1'b0;
        end else begin
            gap <= gap_next;
        end
    end
`endif

endmodule
